uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 128 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes framed UART commands into channel trigger/vector registers and read-back responses.
// Ports:
//   clk, nrst           - clock, synchronous active-low reset
//   rx_data/valid/err   - received byte stream from the UART receiver
//   tx_data/valid/ready - response byte stream to the UART transmitter
//   trigout_chN/vctrout_chN (N=0..3) - per-channel trigger level and vector registers
//   trig_en             - global trigger enable
//   idle/busy           - FSM parked in IDLE / not in IDLE
//   cmd_err             - one-cycle error strobe
module uart_cmd_parser #(
    parameter int TIMEOUT_CYC = 12000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] trigout_ch0,
    output logic [7:0] trigout_ch1,
    output logic [7:0] trigout_ch2,
    output logic [7:0] trigout_ch3,
    output logic [7:0] vctrout_ch0,
    output logic [7:0] vctrout_ch1,
    output logic [7:0] vctrout_ch2,
    output logic [7:0] vctrout_ch3,
    output logic       trig_en,
    output logic       idle,
    output logic       busy,
    output logic       cmd_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [2:0] {IDLE, ARG1, ARG2, ARG3, RSP0, RSP1, RSP2} state_t;
    state_t state, state_n;
    logic [7:0] hdr, ch, targ, snap_t, snap_v;
    logic [3:0][7:0] trig, vctr;
    logic [TW-1:0] tmo;
    logic in_arg, tmo_hit, err_n, wr, te_wr, snap;
    assign in_arg  = state == ARG1 || state == ARG2 || state == ARG3;
    assign tmo_hit = tmo == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk)
        state <= !nrst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        wr      = 1'b0;
        te_wr   = 1'b0;
        snap    = 1'b0;
        case (state)
            IDLE: if (rx_valid) begin
                if (rx_data == 8'h5C || rx_data == 8'h53 || rx_data == 8'hA5) state_n = ARG1;
                else err_n = rx_data != 8'h00;
            end
            ARG1, ARG2, ARG3: if (rx_err) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end else if (rx_valid) begin
                if (state == ARG1 && hdr == 8'h5C) begin
                    te_wr   = 1'b1;
                    state_n = IDLE;
                end else if (state == ARG1 && hdr == 8'hA5) begin
                    snap    = rx_data < 8'd4;
                    err_n   = !snap;
                    state_n = snap ? RSP0 : IDLE;
                end else if (state == ARG3) begin
                    wr      = ch < 8'd4;
                    err_n   = !wr;
                    state_n = IDLE;
                end else begin
                    state_n = state == ARG1 ? ARG2 : ARG3;
                end
            end else if (tmo_hit) begin
                // silence too long mid-frame: drop the frame, nothing is written
                state_n = IDLE;
                err_n   = 1'b1;
            end
            default: begin
                // bytes arriving while answering are dropped but still flagged
                err_n = rx_valid;
                if (tx_ready) state_n = state == RSP0 ? RSP1 : state == RSP1 ? RSP2 : IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!nrst) begin
            hdr     <= '0;
            ch      <= '0;
            targ    <= '0;
            snap_t  <= '0;
            snap_v  <= '0;
            trig    <= '0;
            vctr    <= '0;
            tmo     <= '0;
            trig_en <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= err_n;
            // counts only while waiting in an argument state; any accepted byte or exit clears it
            tmo <= (in_arg && state_n == state && !rx_valid) ? tmo + TW'(1) : '0;
            if (state == IDLE && rx_valid) hdr <= rx_data;
            if (state == ARG1 && rx_valid) ch <= rx_data;
            if (state == ARG2 && rx_valid) targ <= rx_data;
            if (te_wr) trig_en <= rx_data[0];
            if (wr) begin
                trig[ch[1:0]] <= targ;
                vctr[ch[1:0]] <= rx_data;
            end
            if (snap) begin
                snap_t <= trig[rx_data[1:0]];
                snap_v <= vctr[rx_data[1:0]];
            end
        end
    end
    assign tx_valid    = state == RSP0 || state == RSP1 || state == RSP2;
    assign tx_data     = state == RSP0 ? 8'hA5 : state == RSP1 ? snap_t : state == RSP2 ? snap_v : 8'h00;
    assign idle        = state == IDLE;
    assign busy        = !idle;
    assign trigout_ch0 = trig[0];
    assign trigout_ch1 = trig[1];
    assign trigout_ch2 = trig[2];
    assign trigout_ch3 = trig[3];
    assign vctrout_ch0 = vctr[0];
    assign vctrout_ch1 = vctr[1];
    assign vctrout_ch2 = vctr[2];
    assign vctrout_ch3 = vctr[3];
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized frames checked against a frame-level model of the command set.
module tb_uart_cmd_parser;
    localparam int T = 40;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0, rx_err = 1'b0, tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic tx_valid, trig_en, idle, busy, cmd_err;
    logic [7:0] trigout_ch0, trigout_ch1, trigout_ch2, trigout_ch3;
    logic [7:0] vctrout_ch0, vctrout_ch1, vctrout_ch2, vctrout_ch3;
    logic [7:0] d_trig [4];
    logic [7:0] d_vctr [4];
    logic [7:0] m_trig [4];
    logic [7:0] m_vctr [4];
    logic m_te;
    int checks = 0, errors = 0, err_cnt = 0;

    uart_cmd_parser #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .trigout_ch0(trigout_ch0), .trigout_ch1(trigout_ch1), .trigout_ch2(trigout_ch2), .trigout_ch3(trigout_ch3),
        .vctrout_ch0(vctrout_ch0), .vctrout_ch1(vctrout_ch1), .vctrout_ch2(vctrout_ch2), .vctrout_ch3(vctrout_ch3),
        .trig_en(trig_en), .idle(idle), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (cmd_err === 1'b1) err_cnt++;

    assign d_trig[0] = trigout_ch0;
    assign d_trig[1] = trigout_ch1;
    assign d_trig[2] = trigout_ch2;
    assign d_trig[3] = trigout_ch3;
    assign d_vctr[0] = vctrout_ch0;
    assign d_vctr[1] = vctrout_ch1;
    assign d_vctr[2] = vctrout_ch2;
    assign d_vctr[3] = vctrout_ch3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s trigout_ch%0d", tag, i), 32'(d_trig[i]), 32'(m_trig[i]));
            chk($sformatf("%s vctrout_ch%0d", tag, i), 32'(d_vctr[i]), 32'(m_vctr[i]));
        end
        chk({tag, " trig_en"}, 32'(trig_en), 32'(m_te));
    endtask

    task automatic settle_err(input string tag, input int e0, input int exp);
        tick();
        tick();
        chk({tag, " cmd_err pulses"}, 32'(err_cnt - e0), 32'(exp));
        chk({tag, " idle"}, 32'(idle), 32'd1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_trig[i] = 8'h00;
            m_vctr[i] = 8'h00;
        end
        m_te = 1'b0;
    endtask

    task automatic do_trig(input logic [7:0] arg, input int gap);
        int e0 = err_cnt;
        send(8'h5C, gap);
        send(arg, gap);
        m_te = arg[0];
        chk("trig latency", 32'(trig_en), 32'(m_te));
        settle_err("trig", e0, 0);
        chk_regs("trig");
    endtask

    task automatic do_write(input logic [7:0] ch, input logic [7:0] t, input logic [7:0] v, input int gap);
        int e0 = err_cnt;
        send(8'h53, gap);
        send(ch, gap);
        send(t, gap);
        send(v, gap);
        if (ch < 4) begin
            m_trig[ch] = t;
            m_vctr[ch] = v;
        end
        chk_regs("write latency");
        settle_err("write", e0, ch < 4 ? 0 : 1);
    endtask

    task automatic do_read(input logic [7:0] ch, input int stall, input int gap);
        int e0 = err_cnt;
        logic [7:0] exp [3];
        send(8'hA5, gap);
        send(ch, gap);
        if (ch < 4) begin
            exp[0] = 8'hA5;
            exp[1] = m_trig[ch];
            exp[2] = m_vctr[ch];
            for (int k = 0; k < 3; k++) begin
                repeat (stall) begin
                    chk($sformatf("rsp%0d stall tx_valid", k), 32'(tx_valid), 32'd1);
                    chk($sformatf("rsp%0d stall tx_data", k), 32'(tx_data), 32'(exp[k]));
                    tick();
                end
                tx_ready = 1'b1;
                chk($sformatf("rsp%0d tx_valid", k), 32'(tx_valid), 32'd1);
                chk($sformatf("rsp%0d tx_data", k), 32'(tx_data), 32'(exp[k]));
                tick();
                tx_ready = 1'b0;
            end
        end
        chk("read end tx_valid", 32'(tx_valid), 32'd0);
        settle_err("read", e0, ch < 4 ? 0 : 1);
    endtask

    task automatic do_one(input logic [7:0] b, input int gap);
        int e0 = err_cnt;
        send(b, gap);
        settle_err($sformatf("header %0h", b), e0, b != 8'h00 ? 1 : 0);
    endtask

    initial begin
        int e0;
        model_reset();
        tick();
        tick();
        chk("reset idle", 32'(idle), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset tx_data", 32'(tx_data), 32'd0);
        chk("reset cmd_err", 32'(cmd_err), 32'd0);
        chk_regs("reset");
        nrst = 1'b1;
        tick();

        do_trig(8'h01, 0);
        do_trig(8'h00, 0);
        do_write(8'd2, 8'h11, 8'h22, 0);
        do_read(8'd2, 5, 0);

        // timeout after a partial channel write
        e0 = err_cnt;
        send(8'h53, 0);
        send(8'h01, 0);
        repeat (T - 1) @(posedge clk);
        #1;
        chk("timeout not yet", 32'(busy), 32'd1);
        tick();
        chk("timeout abort idle", 32'(idle), 32'd1);
        chk("timeout cmd_err", 32'(cmd_err), 32'd1);
        settle_err("timeout", e0, 1);
        chk_regs("timeout");
        do_write(8'd1, 8'h33, 8'h44, 0);

        // a byte on the last timeout cycle wins over the timeout
        e0 = err_cnt;
        send(8'h53, 0);
        send(8'h03, 0);
        send(8'h5A, T - 1);
        chk("tmo boundary busy", 32'(busy), 32'd1);
        send(8'h6B, T - 1);
        m_trig[3] = 8'h5A;
        m_vctr[3] = 8'h6B;
        chk_regs("tmo boundary");
        settle_err("tmo boundary", e0, 0);

        do_write(8'd7, 8'hAA, 8'hBB, 0);
        do_one(8'h7E, 0);
        do_one(8'h00, 0);

        // framing error: aborts mid-frame, ignored in IDLE
        e0 = err_cnt;
        send(8'h53, 0);
        send(8'h00, 0);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        chk("rx_err abort idle", 32'(idle), 32'd1);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        settle_err("rx_err", e0, 1);
        chk_regs("rx_err");

        // byte arriving during a response is dropped and flagged
        e0 = err_cnt;
        send(8'hA5, 0);
        send(8'h01, 0);
        send(8'h99, 0);
        chk("rsp drop err", 32'(cmd_err), 32'd1);
        chk("rsp drop tx_data", 32'(tx_data), 32'hA5);
        tx_ready = 1'b1;
        tick();
        chk("rsp b2b byte1", 32'(tx_data), 32'(m_trig[1]));
        tick();
        chk("rsp b2b byte2", 32'(tx_data), 32'(m_vctr[1]));
        tick();
        tx_ready = 1'b0;
        chk("rsp b2b done", 32'(tx_valid), 32'd0);
        settle_err("rsp drop", e0, 1);

        // reset in the middle of a channel write
        do_trig(8'h01, 0);
        send(8'h53, 0);
        send(8'h00, 0);
        chk("pre-reset busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        tick();
        model_reset();
        chk("midreset idle", 32'(idle), 32'd1);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset tx_valid", 32'(tx_valid), 32'd0);
        chk("midreset tx_data", 32'(tx_data), 32'd0);
        chk("midreset cmd_err", 32'(cmd_err), 32'd0);
        chk_regs("midreset");
        nrst = 1'b1;
        tick();
        do_trig(8'h01, 0);

        // random frames
        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 4);
            int gap = $urandom_range(0, 3);
            logic [7:0] ch = 8'($urandom_range(0, 5));
            logic [7:0] b = 8'($urandom);
            case (kind)
                0: do_trig(b, gap);
                1: do_write(ch, 8'($urandom), 8'($urandom), gap);
                2: do_read(ch, $urandom_range(0, 3), gap);
                default: do_one((b == 8'h5C || b == 8'h53 || b == 8'hA5) ? 8'h00 : b, gap);
            endcase
        end
        chk_regs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
